// File: rtl/conv_window_scanner_if.sv
// Window-scanner handshake bundle: start/abort control plus the valid/ready window beat stream.
interface conv_window_scanner_if #(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic              out_ready;
    logic              out_valid;
    logic [IDX_W-1:0]  win_row;
    logic [IDX_W-1:0]  win_col;
    logic [CH_W-1:0]   win_ch;
    logic [ADDR_W-1:0] out_idx;
    logic              first;
    logic              last;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, out_ready,
        input  out_valid, win_row, win_col, win_ch, out_idx, first, last, busy, done
    );

    modport slave (
        input  start, abort, out_ready,
        output out_valid, win_row, win_col, win_ch, out_idx, first, last, busy, done
    );
endinterface

// File: rtl/conv_window_scanner.sv
// Raster-order convolution window sequencer: emits top-left (row, col, channel) of every
// filter window over the feature map as a valid/ready stream with a start/done handshake.
module conv_window_scanner #(
    parameter int unsigned IMG_ROWS = 28,
    parameter int unsigned IMG_COLS = 28,
    parameter int unsigned FIL_ROWS = 3,
    parameter int unsigned FIL_COLS = 3,
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned CH_W     = 4,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_window_scanner_if.slave bus
);
    localparam int unsigned OUT_ROWS = (IMG_ROWS - FIL_ROWS) / STRIDE + 1;
    localparam int unsigned OUT_COLS = (IMG_COLS - FIL_COLS) / STRIDE + 1;
    localparam int unsigned LAST_ROW = (OUT_ROWS - 1) * STRIDE;
    localparam int unsigned LAST_COL = (OUT_COLS - 1) * STRIDE;
    localparam int unsigned LAST_CH  = CHANNELS - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_win_row;
    logic [IDX_W-1:0]  r_win_col;
    logic [CH_W-1:0]   r_win_ch;
    logic [ADDR_W-1:0] r_out_idx;
    logic [IDX_W-1:0]  w_row_nxt;
    logic [IDX_W-1:0]  w_col_nxt;
    logic [CH_W-1:0]   w_ch_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;
    logic              w_ch_wrap;
    logic              w_col_wrap;
    logic              w_row_end;
    logic              w_first;
    logic              w_last;

    // Wrap decodes compare against precomputed pixel offsets, so no multiplier is needed.
    assign w_ch_wrap  = (r_win_ch  == CH_W'(LAST_CH));
    assign w_col_wrap = (r_win_col == IDX_W'(LAST_COL));
    assign w_row_end  = (r_win_row == IDX_W'(LAST_ROW));
    assign w_accept   = r_out_valid && bus.out_ready;
    assign w_first    = r_out_valid && (r_win_row == '0) && (r_win_col == '0) && (r_win_ch == '0);
    assign w_last     = r_out_valid && w_ch_wrap && w_col_wrap && w_row_end;

    // Next-state and counter advance; abort overrides start and any same-cycle handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_win_row;
        w_col_nxt   = r_win_col;
        w_ch_nxt    = r_win_ch;
        w_idx_nxt   = r_out_idx;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_ch_nxt    = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_last) begin
                            w_state_nxt = S_DONE;
                            w_row_nxt   = '0;
                            w_col_nxt   = '0;
                            w_ch_nxt    = '0;
                            w_idx_nxt   = '0;
                        end else if (!w_ch_wrap) begin
                            w_ch_nxt = r_win_ch + CH_W'(1);
                        end else begin
                            w_ch_nxt  = '0;
                            w_idx_nxt = r_out_idx + ADDR_W'(1);
                            if (w_col_wrap) begin
                                w_col_nxt = '0;
                                w_row_nxt = r_win_row + IDX_W'(STRIDE);
                            end else begin
                                w_col_nxt = r_win_col + IDX_W'(STRIDE);
                            end
                        end
                    end
                end
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_win_ch    <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_row   <= w_row_nxt;
            r_win_col   <= w_col_nxt;
            r_win_ch    <= w_ch_nxt;
            r_out_idx   <= w_idx_nxt;
            r_out_valid <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;
    assign bus.win_ch    = r_win_ch;
    assign bus.out_idx   = r_out_idx;
    assign bus.first     = w_first;
    assign bus.last      = w_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_conv_window_scanner.sv
// Scoreboard bench for conv_window_scanner: three configurations, directed expected beats
// queued by the stimulus thread and compared by a negedge monitor.
module tb_conv_window_scanner;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CH_W   = 4;
    localparam int unsigned ADDR_W = 10;

    typedef struct packed {
        int   row;
        int   col;
        int   ch;
        int   idx;
        logic first;
        logic last;
    } beat_t;

    typedef struct packed {
        logic valid;
        logic busy;
        logic done;
        logic ready;
        logic abort;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_window_scanner_if #(.IDX_W(IDX_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) ifa ();
    conv_window_scanner_if #(.IDX_W(IDX_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) ifb ();
    conv_window_scanner_if #(.IDX_W(IDX_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) ifc ();

    conv_window_scanner #(
        .IMG_ROWS(3), .IMG_COLS(5), .FIL_ROWS(2), .FIL_COLS(2), .STRIDE(1), .CHANNELS(1),
        .IDX_W(IDX_W), .CH_W(CH_W), .ADDR_W(ADDR_W)
    ) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));

    conv_window_scanner #(
        .IMG_ROWS(7), .IMG_COLS(7), .FIL_ROWS(3), .FIL_COLS(3), .STRIDE(2), .CHANNELS(3),
        .IDX_W(IDX_W), .CH_W(CH_W), .ADDR_W(ADDR_W)
    ) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

    conv_window_scanner #(
        .IMG_ROWS(2), .IMG_COLS(2), .FIL_ROWS(2), .FIL_COLS(2), .STRIDE(1), .CHANNELS(1),
        .IDX_W(IDX_W), .CH_W(CH_W), .ADDR_W(ADDR_W)
    ) u_dut_c (.clk(clk), .reset(reset), .bus(ifc));

    int    n_chk  = 0;
    int    n_pass = 0;
    beat_t q_a[$];
    beat_t q_b[$];
    beat_t q_c[$];

    logic  prev_valid[3];
    logic  prev_ready[3];
    logic  prev_abort[3];
    logic  prev_last_acc[3];
    beat_t prev_beat[3];
    int    hs_cnt[3]   = '{0, 0, 0};
    int    done_cnt[3] = '{0, 0, 0};

    task automatic chk(input bit ok, input string name, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic string fmt(input beat_t b);
        return $sformatf("(r%0d c%0d ch%0d i%0d f%0b l%0b)", b.row, b.col, b.ch, b.idx, b.first, b.last);
    endfunction

    function automatic beat_t cur_beat(input int id);
        beat_t b;
        case (id)
            0: begin b.row = int'(ifa.win_row); b.col = int'(ifa.win_col); b.ch = int'(ifa.win_ch);
                     b.idx = int'(ifa.out_idx); b.first = ifa.first; b.last = ifa.last; end
            1: begin b.row = int'(ifb.win_row); b.col = int'(ifb.win_col); b.ch = int'(ifb.win_ch);
                     b.idx = int'(ifb.out_idx); b.first = ifb.first; b.last = ifb.last; end
            default: begin b.row = int'(ifc.win_row); b.col = int'(ifc.win_col); b.ch = int'(ifc.win_ch);
                     b.idx = int'(ifc.out_idx); b.first = ifc.first; b.last = ifc.last; end
        endcase
        return b;
    endfunction

    function automatic ctl_t cur_ctl(input int id);
        ctl_t c;
        case (id)
            0: begin c.valid = ifa.out_valid; c.busy = ifa.busy; c.done = ifa.done;
                     c.ready = ifa.out_ready; c.abort = ifa.abort; end
            1: begin c.valid = ifb.out_valid; c.busy = ifb.busy; c.done = ifb.done;
                     c.ready = ifb.out_ready; c.abort = ifb.abort; end
            default: begin c.valid = ifc.out_valid; c.busy = ifc.busy; c.done = ifc.done;
                     c.ready = ifc.out_ready; c.abort = ifc.abort; end
        endcase
        return c;
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic push_exp(input int id, input beat_t b);
        case (id)
            0: q_a.push_back(b);
            1: q_b.push_back(b);
            default: q_c.push_back(b);
        endcase
    endtask

    task automatic pop_exp(input int id, output beat_t b);
        case (id)
            0: b = q_a.pop_front();
            1: b = q_b.pop_front();
            default: b = q_c.pop_front();
        endcase
    endtask

    task automatic set_start(input int id, input logic v);
        case (id)
            0: ifa.start = v;
            1: ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    task automatic set_ready(input int id, input logic v);
        case (id)
            0: ifa.out_ready = v;
            1: ifb.out_ready = v;
            default: ifc.out_ready = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor step for one instance: hold under stall, done timing, and in-order beat compare.
    task automatic mon_step(input int id);
        beat_t b;
        beat_t e;
        ctl_t  c;
        bit    acc;
        b = cur_beat(id);
        c = cur_ctl(id);
        if (reset) begin
            prev_valid[id]    = 1'b0;
            prev_ready[id]    = 1'b1;
            prev_abort[id]    = 1'b0;
            prev_last_acc[id] = 1'b0;
            return;
        end
        if (prev_valid[id] && !prev_ready[id] && !prev_abort[id])
            chk(c.valid && (b == prev_beat[id]), "hold",
                $sformatf("inst%0d got v=%0b %s required v=1 %s", id, c.valid, fmt(b), fmt(prev_beat[id])));
        if (c.done || prev_last_acc[id]) begin
            chk(c.done == prev_last_acc[id], "done_pulse",
                $sformatf("inst%0d got done=%0b required %0b", id, c.done, prev_last_acc[id]));
            if (c.done) done_cnt[id]++;
        end
        acc = c.valid && c.ready && !c.abort;
        if (acc) begin
            if (qsize(id) == 0) begin
                chk(1'b0, "extra_beat", $sformatf("inst%0d got %s required none", id, fmt(b)));
            end else begin
                pop_exp(id, e);
                chk((b == e) && c.busy, "beat",
                    $sformatf("inst%0d got %s busy=%0b required %s busy=1", id, fmt(b), c.busy, fmt(e)));
            end
            hs_cnt[id]++;
        end
        prev_last_acc[id] = acc && b.last;
        prev_valid[id]    = c.valid;
        prev_ready[id]    = c.ready;
        prev_abort[id]    = c.abort;
        prev_beat[id]     = b;
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
        mon_step(2);
    end

    // 3x5 map, 2x2 filter, stride 1: two window rows of four columns.
    task automatic push_a(input int n);
        int    a_row[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int    a_col[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.row = a_row[i]; e.col = a_col[i]; e.ch = 0; e.idx = i;
            e.first = (i == 0); e.last = (i == 7);
            push_exp(0, e);
        end
    endtask

    // 7x7 map, 3x3 filter, stride 2, 3 channels: offsets {0,2,4} in each axis.
    task automatic push_b();
        beat_t e;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int ch = 0; ch < 3; ch++) begin
                    e.row = 2 * r; e.col = 2 * c; e.ch = ch; e.idx = 3 * r + c;
                    e.first = (r == 0 && c == 0 && ch == 0);
                    e.last  = (r == 2 && c == 2 && ch == 2);
                    push_exp(1, e);
                end
    endtask

    task automatic push_c();
        beat_t e;
        e = '0;
        e.first = 1'b1;
        e.last  = 1'b1;
        push_exp(2, e);
    endtask

    task automatic run_scan(input int id, input bit rand_ready, input int restart_at, input int exp_beats);
        int    base_done;
        int    base_hs;
        ctl_t  c;
        beat_t b;
        base_done = done_cnt[id];
        base_hs   = hs_cnt[id];
        set_start(id, 1'b1);
        tick();
        set_start(id, 1'b0);
        c = cur_ctl(id);
        b = cur_beat(id);
        chk(c.valid && c.busy && b.first, "start_latency",
            $sformatf("inst%0d got v=%0b busy=%0b first=%0b required 1 1 1", id, c.valid, c.busy, b.first));
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done_cnt[id] != base_done) break;
            if (rand_ready) set_ready(id, 1'($urandom_range(0, 1)));
            set_start(id, logic'(cyc == restart_at));
            tick();
        end
        set_start(id, 1'b0);
        set_ready(id, 1'b1);
        chk(done_cnt[id] == base_done + 1, "done_count",
            $sformatf("inst%0d got %0d required %0d", id, done_cnt[id] - base_done, 1));
        chk(hs_cnt[id] - base_hs == exp_beats, "handshakes",
            $sformatf("inst%0d got %0d required %0d", id, hs_cnt[id] - base_hs, exp_beats));
        c = cur_ctl(id);
        chk(!c.valid && !c.busy && !c.done, "idle_after_done",
            $sformatf("inst%0d got v=%0b busy=%0b done=%0b required 0 0 0", id, c.valid, c.busy, c.done));
    endtask

    initial begin
        ctl_t  c;
        beat_t b;
        int    base_hs;
        int    base_done;

        reset = 1'b0;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.out_ready = 1'b1;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.out_ready = 1'b1;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.out_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        for (int id = 0; id < 3; id++) begin
            c = cur_ctl(id);
            b = cur_beat(id);
            chk(!c.valid && !c.busy && !c.done && (b == beat_t'(0)), "reset_state",
                $sformatf("inst%0d got v=%0b busy=%0b done=%0b %s required all 0",
                          id, c.valid, c.busy, c.done, fmt(b)));
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        push_a(8);
        run_scan(0, 1'b0, -1, 8);

        push_b();
        run_scan(1, 1'b0, -1, 27);

        push_a(8);
        run_scan(0, 1'b1, -1, 8);

        // Abort while beat 3 is presented with out_ready high.
        push_a(3);
        base_hs   = hs_cnt[0];
        base_done = done_cnt[0];
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        for (int cyc = 0; cyc < 50 && hs_cnt[0] < base_hs + 3; cyc++) tick();
        b = cur_beat(0);
        chk(b.row == 0 && b.col == 3 && b.idx == 3, "abort_beat3",
            $sformatf("got %s required (r0 c3 ch0 i3)", fmt(b)));
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        c = cur_ctl(0);
        b = cur_beat(0);
        chk(!c.valid && !c.busy && !c.done && (b == beat_t'(0)), "abort_idle",
            $sformatf("got v=%0b busy=%0b done=%0b %s required all 0", c.valid, c.busy, c.done, fmt(b)));
        repeat (4) tick();
        chk(done_cnt[0] == base_done, "abort_no_done",
            $sformatf("got %0d done pulses required 0", done_cnt[0] - base_done));
        push_a(8);
        run_scan(0, 1'b0, -1, 8);

        push_a(8);
        run_scan(0, 1'b0, 2, 8);

        push_c();
        run_scan(2, 1'b0, -1, 1);

        // Asynchronous reset between clock edges while beat 3 is presented.
        push_a(3);
        base_hs = hs_cnt[0];
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        for (int cyc = 0; cyc < 50 && hs_cnt[0] < base_hs + 3; cyc++) tick();
        #1 reset = 1'b1;
        #1;
        c = cur_ctl(0);
        b = cur_beat(0);
        chk(!c.valid && !c.busy && !c.done && (b == beat_t'(0)), "async_reset",
            $sformatf("got v=%0b busy=%0b done=%0b %s required all 0", c.valid, c.busy, c.done, fmt(b)));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick();
        c = cur_ctl(0);
        chk(!c.valid && !c.busy, "reset_wait_idle",
            $sformatf("got v=%0b busy=%0b required 0 0", c.valid, c.busy));

        for (int id = 0; id < 3; id++)
            chk(qsize(id) == 0, "queue_drained",
                $sformatf("inst%0d got %0d pending required 0", id, qsize(id)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
